bmlp_dmem_ctrl: RTL and testbench
=================================

# bmlp_dmem_ctrl

Parametrised, writable data memory for the binary-MLP datapath, holding one DATA_W-bit word per address. A sequential init sweep after reset (or on request) fills the array with a periodic 0/1 pattern. It also provides a single-cycle registered read port with valid/error flags and a write port that neural-layer update logic uses to overwrite entries. It sits between the layer sequencer (address/enable source) and the accumulator datapath (rd_data consumer).

## Interface
- DATA_W, 9: word width in bits.
- DEPTH, 112: number of words.
- ADDR_W, 7: address width; must satisfy 2^ADDR_W >= DEPTH.
- INIT_PAT, 4'b0011: init value of entry i is zero-extended INIT_PAT[i mod 4]; the default gives the sequence 1,1,0,0,1,1,0,0,...
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- init_start  in  1  request a re-initialisation sweep; honoured only in READY.
- busy  out  1  high while in INIT; all rd/wr requests are ignored.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data updated by an accepted read.
- rd_err  out  1  qualifies rd_valid: address was >= DEPTH.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_err  out  1  one-cycle pulse: accepted write had address >= DEPTH and was dropped.

## Operation
- FSM states: INIT, READY.
- Reset (rst=0 at an edge) sets the following: state=INIT, init_ptr=0, busy=1, rd_data=0, rd_valid=0, rd_err=0, wr_err=0. Array contents are not touched by reset.
- INIT behaviour:
  - Each edge writes mem[init_ptr] = {(DATA_W-1)'b0, INIT_PAT[init_ptr[1:0]]}, then init_ptr++.
  - On the edge that writes entry DEPTH-1: state<=READY, busy<=0, init_ptr<=0.
  - rd_en, wr_en and init_start are ignored. rd_valid, rd_err and wr_err stay 0; rd_data holds its value.
- READY, read accepted when rd_en=1:
  - If rd_addr < DEPTH: rd_data<=mem[rd_addr], rd_valid<=1, rd_err<=0.
  - Otherwise: rd_data<=0, rd_valid<=1, rd_err<=1.
- READY with rd_en=0: rd_valid<=0, rd_err<=0, rd_data holds its last value.
- READY, write accepted when wr_en=1:
  - If wr_addr < DEPTH: mem[wr_addr]<=wr_data, wr_err<=0.
  - Otherwise: no array change, wr_err<=1.
- READY with wr_en=0: wr_err<=0.
- Read and write in the same cycle are both accepted. With rd_addr==wr_addr, the read returns the OLD word (read-first); the new word is visible from the next read.
- init_start=1 in READY: state<=INIT, busy<=1, init_ptr<=0. A read or write presented in that same cycle is still accepted and completes normally.
- init_start in INIT has no effect; the sweep does not restart.
- rst low mid-sweep restarts the sweep from entry 0. Partially written entries are overwritten.
- Address comparison is unsigned. No arithmetic wrap: init_ptr never exceeds DEPTH-1.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data/rd_valid/rd_err valid after edge N, for one cycle.
- Back-to-back reads every cycle are supported, giving one result per cycle.
- Write takes effect at the sampling edge and is visible to a read issued on the next cycle.
- Init sweep takes exactly DEPTH cycles:
  - If edges 1..DEPTH are the first with rst=1, busy falls at edge DEPTH.
  - The first accepted request is sampled at edge DEPTH+1.
- busy is registered and never combinationally depends on inputs.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then release; read addresses 0..111 after busy falls. Required response:
  - busy high for exactly 112 cycles.
  - rd_data = 1,1,0,0,... repeating (addr 110 -> 0, addr 111 -> 0).
  - rd_valid one cycle after each rd_en, rd_err=0.
- Write 9'h1A5 to addr 6, then read addr 6 on the following cycle. Required: rd_data=9'h1A5.
- Same-cycle write 9'h0FF and read of addr 3 (holding 0). Required: rd_data=0; next read of addr 3 returns 9'h0FF.
- Read addr 115 and write addr 120 with data 9'h111. Required:
  - rd_valid=1, rd_err=1, rd_data=0.
  - wr_err pulses for one cycle.
  - A full readback shows no entry changed.
- Write 9'h1FF to all entries, then pulse init_start. Required:
  - busy=1 for 112 cycles.
  - rd_en during the sweep yields no rd_valid.
  - Readback restores the 1,1,0,0 pattern.
- Pull rst low at sweep cycle 50, then release. Required: busy stays high for a full 112 cycles from release, and the final contents match the pattern.

Source files
------------

// File: rtl/bmlp_dmem_ctrl.sv
// Writable word memory for the binary-MLP datapath: a periodic-pattern init sweep,
// a registered read port with valid/error flags, and a write port for layer updates.
module bmlp_dmem_ctrl #(
  parameter int         DATA_W   = 9,
  parameter int         DEPTH    = 112,
  parameter int         ADDR_W   = 7,
  parameter logic [3:0] INIT_PAT = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  output logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] init_word;

  assign rd_ok     = 32'(rd_addr) < DEPTH;
  assign wr_ok     = 32'(wr_addr) < DEPTH;
  assign init_word = DATA_W'(INIT_PAT[init_ptr[1:0]]);

  // Array has no reset; a reset edge itself writes nothing so the sweep
  // starts cleanly at entry 0 on the first edge with rst high.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_INIT) begin
        mem[init_ptr] <= init_word;
      end else if (wr_en && wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Control and read port; mem is sampled before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
      busy     <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          rd_valid <= 1'b0;
          rd_err   <= 1'b0;
          wr_err   <= 1'b0;
          if (init_ptr == LAST_ADDR) begin
            state    <= S_READY;
            busy     <= 1'b0;
            init_ptr <= '0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        S_READY: begin
          rd_valid <= rd_en;
          rd_err   <= rd_en && !rd_ok;
          wr_err   <= wr_en && !wr_ok;
          if (rd_en) begin
            rd_data <= rd_ok ? mem[rd_addr] : '0;
          end
          if (init_start) begin
            state    <= S_INIT;
            busy     <= 1'b1;
            init_ptr <= '0;
          end
        end
        default: begin
          state <= S_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmlp_dmem_ctrl.sv
// Randomized and directed bench for bmlp_dmem_ctrl against a per-cycle behavioural
// model (word array + remaining-sweep counter).
module tb_bmlp_dmem_ctrl;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 112;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_start;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  bmlp_dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_PAT(4'b0011)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory words, words left in the current sweep, last read data.
  int mdl_mem [DEPTH];
  int sweep_left;
  int rd_last;
  int busy_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pat_word(input int idx);
    int pat;
    pat = 3;  // 4'b0011
    return (pat >> (idx % 4)) & 1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; init_start = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    sweep_left = DEPTH;
    rd_last = 0;
    busy_cycles = 0;
    rst = 1'b1;
  endtask

  task automatic do_cycle(input bit re, input int ra, input bit we, input int wa,
                          input int wd, input bit is);
    int exp_valid, exp_err, exp_werr, exp_busy, old_word;
    rd_en = re; rd_addr = ADDR_W'(ra);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd);
    init_start = is;
    @(posedge clk); #1;
    if (sweep_left > 0) begin
      mdl_mem[DEPTH - sweep_left] = pat_word(DEPTH - sweep_left);
      sweep_left--;
      busy_cycles++;
      exp_valid = 0; exp_err = 0; exp_werr = 0;
    end else begin
      exp_valid = re;
      exp_err   = (re && ra >= DEPTH) ? 1 : 0;
      exp_werr  = (we && wa >= DEPTH) ? 1 : 0;
      if (re) begin
        old_word = (ra >= DEPTH) ? 0 : mdl_mem[ra];
        rd_last  = old_word;
      end
      if (we && wa < DEPTH) mdl_mem[wa] = wd;
      if (is) sweep_left = DEPTH;
    end
    exp_busy = (sweep_left > 0) ? 1 : 0;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_err", 32'(rd_err), 32'(exp_err));
    chk("wr_err", 32'(wr_err), 32'(exp_werr));
    chk("rd_data", 32'(rd_data), 32'(rd_last));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Readback also checks directly against the fixed pattern when requested.
  task automatic readback(input bit vs_pattern);
    for (int a = 0; a < DEPTH; a++) begin
      do_cycle(1, a, 0, 0, 0, 0);
      if (vs_pattern) chk("pattern", 32'(rd_data), 32'(pat_word(a)));
    end
  endtask

  initial begin
    rst = 1'b0; init_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sweep_left = DEPTH; rd_last = 0; busy_cycles = 0;
    @(posedge clk);
    do_reset();

    // Power-up sweep then full pattern readback.
    idle(DEPTH);
    chk("sweep_len", 32'(busy_cycles), DEPTH);
    readback(1);

    // Write then read next cycle.
    do_cycle(0, 0, 1, 6, 9'h1A5, 0);
    do_cycle(1, 6, 0, 0, 0, 0);
    chk("wr_rd_6", 32'(rd_data), 9'h1A5);

    // Same-cycle read/write of one address is read-first.
    do_cycle(1, 3, 1, 3, 9'h0FF, 0);
    chk("rf_old_3", 32'(rd_data), 0);
    do_cycle(1, 3, 0, 0, 0, 0);
    chk("rf_new_3", 32'(rd_data), 9'h0FF);

    // Out-of-range read and write.
    do_cycle(1, 115, 1, 120, 9'h111, 0);
    chk("oor_rd_err", 32'(rd_err), 1);
    chk("oor_wr_err", 32'(wr_err), 1);
    chk("oor_rd_data", 32'(rd_data), 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    chk("oor_wr_err_pulse", 32'(wr_err), 0);
    readback(0);

    // Fill with 1FF, re-init with reads hammering during the sweep.
    for (int a = 0; a < DEPTH; a++) do_cycle(0, 0, 1, a, 9'h1FF, 0);
    busy_cycles = 0;
    do_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1, $urandom_range(0, 127), 1, $urandom_range(0, 127), $urandom_range(0, 511),
               $urandom_range(0, 1));
    chk("reinit_len", 32'(busy_cycles), DEPTH);
    readback(1);

    // Reset in the middle of a sweep.
    do_cycle(0, 0, 0, 0, 0, 1);
    idle(50);
    do_reset();
    idle(DEPTH);
    chk("midrst_len", 32'(busy_cycles), DEPTH);
    readback(1);

    // Random traffic with occasional re-init requests.
    for (int i = 0; i < 600; i++)
      do_cycle($urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 1),
               $urandom_range(0, 127), $urandom_range(0, 511), ($urandom_range(0, 63) == 0));
    idle(DEPTH);
    readback(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
